// File: rtl/mc_control_fsm_if.sv
// Control bus between the multicycle control FSM and the MIPS-subset datapath.
// The master side is the control unit; the slave side is the datapath.
interface mc_control_fsm_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic [2:0] IorD;
  logic       MemOp;
  logic [2:0] ALUSrcA;
  logic [2:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic       PCWrite;
  logic       EPCWrite;
  logic       IRWrite;
  logic       AWrite;
  logic       BWrite;
  logic       ALUWrite;
  logic       MDRWrite;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] MemToReg;
  logic [4:0] state_dbg;

  modport master (
    input  op, funct, zero, overflow,
    output IorD, MemOp, ALUSrcA, ALUSrcB, ALUOp, PCSource,
    output PCWrite, EPCWrite, IRWrite, AWrite, BWrite, ALUWrite, MDRWrite, RegWrite,
    output RegDst, MemToReg, state_dbg
  );

  modport slave (
    output op, funct, zero, overflow,
    input  IorD, MemOp, ALUSrcA, ALUSrcB, ALUOp, PCSource,
    input  PCWrite, EPCWrite, IRWrite, AWrite, BWrite, ALUWrite, MDRWrite, RegWrite,
    input  RegDst, MemToReg, state_dbg
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Moore control FSM for the multicycle MIPS-subset datapath with memory wait
// states and EPC/vectored exceptions. Only the BEQ PC write looks at an input.
module mc_control_fsm #(
  parameter int MEM_WAIT = 1
) (
  input logic              clock,
  input logic              reset,
  mc_control_fsm_if.master bus
);
  typedef enum logic [4:0] {
    S_RESET = 5'd0, S_FETCH = 5'd1, S_FETCH_WAIT = 5'd2, S_IR_LOAD = 5'd3,
    S_DECODE = 5'd4, S_R_EXEC = 5'd5, S_R_WB = 5'd6, S_ADDI_EXEC = 5'd7,
    S_I_WB = 5'd8, S_MEM_ADDR = 5'd9, S_MEM_RD = 5'd10, S_MEM_RD_WAIT = 5'd11,
    S_MEM_LOAD = 5'd12, S_LW_WB = 5'd13, S_MEM_WR = 5'd14, S_BEQ = 5'd15,
    S_JUMP = 5'd16, S_JR = 5'd17, S_EXC = 5'd18, S_EXC_WAIT = 5'd19,
    S_EXC_LOAD = 5'd20, S_EXC_JUMP = 5'd21
  } state_t;

  typedef struct packed {
    logic [2:0] iord;
    logic       memop;
    logic [2:0] alusrca;
    logic [2:0] alusrcb;
    logic [2:0] aluop;
    logic [1:0] pcsource;
    logic       pcwrite;
    logic       epcwrite;
    logic       irwrite;
    logic       awrite;
    logic       bwrite;
    logic       aluwrite;
    logic       mdrwrite;
    logic       regwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
  } ctrl_t;

  localparam logic [3:0] WAIT_LOAD = (MEM_WAIT == 0) ? 4'd0 : 4'(MEM_WAIT - 1);
  localparam bit         NO_WAIT   = (MEM_WAIT == 0);

  state_t     state_q, nxt_state;
  logic [3:0] cnt_q, nxt_cnt;
  logic [2:0] alu_fn_q, nxt_fn;
  logic [2:0] vec_q, nxt_vec;
  ctrl_t      ctrl_q;
  logic       beq_q;

  // Control word for a state; the exception vector and R-type ALU function
  // are passed in because they are latched alongside the state transition.
  function automatic ctrl_t ctrl_for(state_t s, logic [2:0] fn, logic [2:0] v);
    ctrl_t c;
    c = '0;
    case (s)
      S_IR_LOAD: begin
        c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 3'b001; c.aluop = 3'b001;
      end
      S_DECODE: begin
        c.awrite = 1'b1; c.bwrite = 1'b1; c.aluwrite = 1'b1;
        c.alusrcb = 3'b011; c.aluop = 3'b001;
      end
      S_R_EXEC: begin
        c.alusrca = 3'b001; c.aluop = fn; c.aluwrite = 1'b1;
      end
      S_R_WB:   begin c.regwrite = 1'b1; c.regdst = 2'b01; end
      S_ADDI_EXEC, S_MEM_ADDR: begin
        c.alusrca = 3'b001; c.alusrcb = 3'b010; c.aluop = 3'b001; c.aluwrite = 1'b1;
      end
      S_I_WB:   c.regwrite = 1'b1;
      S_MEM_RD, S_MEM_RD_WAIT: c.iord = 3'b001;
      S_MEM_LOAD: begin c.iord = 3'b001; c.mdrwrite = 1'b1; end
      S_LW_WB:  begin c.regwrite = 1'b1; c.memtoreg = 2'b01; end
      S_MEM_WR: begin c.iord = 3'b001; c.memop = 1'b1; end
      S_BEQ:    begin c.alusrca = 3'b001; c.aluop = 3'b010; c.pcsource = 2'b01; end
      S_JUMP:   begin c.pcsource = 2'b10; c.pcwrite = 1'b1; end
      S_JR:     begin c.alusrca = 3'b001; c.pcwrite = 1'b1; end
      S_EXC: begin
        c.epcwrite = 1'b1; c.alusrcb = 3'b001; c.aluop = 3'b010; c.iord = v;
      end
      S_EXC_WAIT: c.iord = v;
      S_EXC_LOAD: begin c.iord = v; c.mdrwrite = 1'b1; end
      S_EXC_JUMP: begin c.pcsource = 2'b11; c.pcwrite = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt_state = S_RESET;
    nxt_cnt   = cnt_q;
    nxt_fn    = alu_fn_q;
    nxt_vec   = vec_q;
    case (state_q)
      S_RESET:      nxt_state = S_FETCH;
      S_FETCH:      begin nxt_cnt = WAIT_LOAD; nxt_state = NO_WAIT ? S_IR_LOAD : S_FETCH_WAIT; end
      S_FETCH_WAIT: begin
        nxt_state = (cnt_q == 4'd0) ? S_IR_LOAD : S_FETCH_WAIT;
        nxt_cnt   = cnt_q - 4'd1;
      end
      S_IR_LOAD:    nxt_state = S_DECODE;
      S_DECODE: begin
        case (bus.funct)
          6'h20:   nxt_fn = 3'b001;
          6'h22:   nxt_fn = 3'b010;
          6'h24:   nxt_fn = 3'b011;
          default: nxt_fn = 3'b000;
        endcase
        case (bus.op)
          6'h00: begin
            if (bus.funct == 6'h20 || bus.funct == 6'h22 || bus.funct == 6'h24)
              nxt_state = S_R_EXEC;
            else if (bus.funct == 6'h08)
              nxt_state = S_JR;
            else begin
              nxt_state = S_EXC; nxt_vec = 3'b011;
            end
          end
          6'h08:        nxt_state = S_ADDI_EXEC;
          6'h23, 6'h2B: nxt_state = S_MEM_ADDR;
          6'h04:        nxt_state = S_BEQ;
          6'h02:        nxt_state = S_JUMP;
          default: begin nxt_state = S_EXC; nxt_vec = 3'b011; end
        endcase
      end
      S_R_EXEC: begin
        // AND cannot overflow, so a stale overflow flag is ignored for it.
        if (bus.overflow && alu_fn_q != 3'b011) begin
          nxt_state = S_EXC; nxt_vec = 3'b010;
        end else nxt_state = S_R_WB;
      end
      S_ADDI_EXEC: begin
        if (bus.overflow) begin nxt_state = S_EXC; nxt_vec = 3'b010; end
        else nxt_state = S_I_WB;
      end
      S_MEM_ADDR: begin
        if (bus.op == 6'h23)      nxt_state = S_MEM_RD;
        else if (bus.op == 6'h2B) nxt_state = S_MEM_WR;
        else                      nxt_state = S_FETCH;
      end
      S_MEM_RD:      begin nxt_cnt = WAIT_LOAD; nxt_state = NO_WAIT ? S_MEM_LOAD : S_MEM_RD_WAIT; end
      S_MEM_RD_WAIT: begin
        nxt_state = (cnt_q == 4'd0) ? S_MEM_LOAD : S_MEM_RD_WAIT;
        nxt_cnt   = cnt_q - 4'd1;
      end
      S_MEM_LOAD:    nxt_state = S_LW_WB;
      S_EXC:         begin nxt_cnt = WAIT_LOAD; nxt_state = NO_WAIT ? S_EXC_LOAD : S_EXC_WAIT; end
      S_EXC_WAIT: begin
        nxt_state = (cnt_q == 4'd0) ? S_EXC_LOAD : S_EXC_WAIT;
        nxt_cnt   = cnt_q - 4'd1;
      end
      S_EXC_LOAD:    nxt_state = S_EXC_JUMP;
      S_R_WB, S_I_WB, S_LW_WB, S_MEM_WR, S_BEQ, S_JUMP, S_JR, S_EXC_JUMP:
                     nxt_state = S_FETCH;
      default:       nxt_state = S_RESET;
    endcase
  end

  // Outputs are registered from the next state so they follow the state with no decode delay.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_RESET;
      cnt_q    <= 4'd0;
      alu_fn_q <= 3'b000;
      vec_q    <= 3'b000;
      ctrl_q   <= '0;
      beq_q    <= 1'b0;
    end else begin
      state_q  <= nxt_state;
      cnt_q    <= nxt_cnt;
      alu_fn_q <= nxt_fn;
      vec_q    <= nxt_vec;
      ctrl_q   <= ctrl_for(nxt_state, nxt_fn, nxt_vec);
      beq_q    <= (nxt_state == S_BEQ);
    end
  end

  assign bus.IorD      = ctrl_q.iord;
  assign bus.MemOp     = ctrl_q.memop;
  assign bus.ALUSrcA   = ctrl_q.alusrca;
  assign bus.ALUSrcB   = ctrl_q.alusrcb;
  assign bus.ALUOp     = ctrl_q.aluop;
  assign bus.PCSource  = ctrl_q.pcsource;
  assign bus.PCWrite   = ctrl_q.pcwrite | (beq_q & bus.zero);
  assign bus.EPCWrite  = ctrl_q.epcwrite;
  assign bus.IRWrite   = ctrl_q.irwrite;
  assign bus.AWrite    = ctrl_q.awrite;
  assign bus.BWrite    = ctrl_q.bwrite;
  assign bus.ALUWrite  = ctrl_q.aluwrite;
  assign bus.MDRWrite  = ctrl_q.mdrwrite;
  assign bus.RegWrite  = ctrl_q.regwrite;
  assign bus.RegDst    = ctrl_q.regdst;
  assign bus.MemToReg  = ctrl_q.memtoreg;
  assign bus.state_dbg = state_q;
endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Parametrised multicycle control unit for the MIPS-subset datapath. It replaces the fixed fetch/decode/ADD sequencer and supports:
- Configurable memory wait states.
- R-type ADD/SUB/AND/JR, ADDI, LW, SW, BEQ and J.
- Overflow and illegal-opcode exceptions through EPC and a memory-held vector.

It drives every datapath mux select and register write enable from a single Moore FSM. The only exception is the BEQ PC write, which is gated by `zero`.

## Interface
- `MEM_WAIT`, default 1: wait cycles inserted after every memory read before data is latched. Legal range 0..15.
- `clock` in 1: sole clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-low. Low forces state RESET immediately.
- `op` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag, combinational from the current ALU inputs.
- `overflow` in 1: ALU signed overflow, combinational.
- `IorD` out 3: memory address select. 000 PC, 001 ALUOut, 010 vector 253, 011 vector 254.
- `MemOp` out 1: 0 read, 1 write.
- `ALUSrcA` out 3: 000 PC, 001 A.
- `ALUSrcB` out 3: 000 B, 001 const 4, 010 sign-ext imm, 011 sign-ext imm<<2.
- `ALUOp` out 3: 000 pass A, 001 add, 010 sub, 011 and.
- `PCSource` out 2: 00 ALU result, 01 ALUOut, 10 jump target, 11 MDR[7:0] zero-extended.
- `PCWrite`, `EPCWrite`, `IRWrite`, `AWrite`, `BWrite`, `ALUWrite`, `MDRWrite`, `RegWrite` out 1 each: write enables.
- `RegDst` out 2: 00 rt, 01 rd.
- `MemToReg` out 2: 00 ALUOut, 01 MDR.
- `state_dbg` out 5: current state encoding.

## Operation
- State encodings: RESET 0, FETCH 1, FETCH_WAIT 2, IR_LOAD 3, DECODE 4, R_EXEC 5, R_WB 6, ADDI_EXEC 7, I_WB 8, MEM_ADDR 9, MEM_RD 10, MEM_RD_WAIT 11, MEM_LOAD 12, LW_WB 13, MEM_WR 14, BEQ 15, JUMP 16, JR 17, EXC 18, EXC_WAIT 19, EXC_LOAD 20, EXC_JUMP 21. Encodings 22–31 go to RESET.
- Outputs are a pure function of state. Any output not listed for a state is 0.
- RESET: all outputs 0. Next state FETCH.
- FETCH: IorD 000, MemOp 0.
- FETCH_WAIT, MEM_RD_WAIT, EXC_WAIT: hold the previous state's IorD/MemOp.
  - A 4-bit counter loads MEM_WAIT-1 on entry and the state exits when the counter is 0.
  - With MEM_WAIT=0 the wait state is skipped entirely.
- IR_LOAD: IRWrite, PCWrite, ALUSrcA 000, ALUSrcB 001, ALUOp 001, PCSource 00, IorD 000.
- DECODE: AWrite, BWrite, ALUWrite, ALUSrcA 000, ALUSrcB 011, ALUOp 001.
  - Latch the internal `alu_fn`: funct 0x20 gives 001, 0x22 gives 010, 0x24 gives 011.
  - Dispatch: op 0 with funct 0x20/0x22/0x24 goes to R_EXEC; op 0 with funct 0x08 goes to JR.
  - op 0x08 goes to ADDI_EXEC; 0x23 or 0x2B goes to MEM_ADDR; 0x04 goes to BEQ; 0x02 goes to JUMP.
  - Anything else goes to EXC with internal `vec`=011.
- R_EXEC: ALUSrcA 001, ALUSrcB 000, ALUOp=`alu_fn`, ALUWrite.
  - If `overflow` is high and `alu_fn`≠011, go to EXC with `vec`=010. Otherwise go to R_WB.
- R_WB: RegWrite, RegDst 01, MemToReg 00. Next state FETCH.
- ADDI_EXEC: ALUSrcA 001, ALUSrcB 010, ALUOp 001, ALUWrite. Overflow goes to EXC with `vec`=010, else I_WB.
- I_WB: RegWrite, RegDst 00, MemToReg 00. Next state FETCH.
- MEM_ADDR: same controls as ADDI_EXEC; overflow is ignored. op 0x23 goes to MEM_RD, op 0x2B goes to MEM_WR.
- MEM_RD: IorD 001, MemOp 0.
- MEM_LOAD: IorD 001, MDRWrite.
- LW_WB: RegWrite, RegDst 00, MemToReg 01. Next state FETCH.
- MEM_WR: IorD 001, MemOp 1. Next state FETCH; writes need no wait.
- BEQ: ALUSrcA 001, ALUSrcB 000, ALUOp 010, PCSource 01, PCWrite=`zero`. Next state FETCH.
- JUMP: PCSource 10, PCWrite. Next state FETCH.
- JR: ALUSrcA 001, ALUOp 000, PCSource 00, PCWrite. Next state FETCH.
- EXC: EPCWrite, ALUSrcA 000, ALUSrcB 001, ALUOp 010 (EPC←PC-4), IorD=`vec`, MemOp 0.
- EXC_LOAD: IorD=`vec`, MDRWrite.
- EXC_JUMP: PCSource 11, PCWrite. Next state FETCH.

## Timing
- Reset assertion is asynchronous. After `reset` rises, the first edge moves RESET to FETCH.
- Reset low mid-instruction aborts the instruction at once. All write enables drop to 0 combinationally; no partial writeback.
- Fetch takes 2+W cycles, where W=MEM_WAIT.
- Total instruction cycles:
  - BEQ, J, JR: 4+W.
  - R-type, ADDI, SW: 5+W.
  - LW: 7+2W.
  - Exception: from EXC entry back to FETCH takes 3+W.
- `overflow` and `zero` are sampled only in R_EXEC/ADDI_EXEC and BEQ respectively.

## Test plan
- MEM_WAIT=2, reset low for 3 cycles mid-R_WB, then high → RegWrite is 0 immediately, `state_dbg` is 0, and 1 on the next edge.
- MEM_WAIT=2, ADD (op 0, funct 0x20) with no overflow → state path 1,2,2,3,4,5,6,1; RegWrite high for exactly one cycle with RegDst 01; 7 cycles total.
- MEM_WAIT=0, LW (op 0x23) → path 1,3,4,9,10,12,13,1; MDRWrite in state 12; MemToReg 01 in state 13.
- BEQ with `zero`=1, then BEQ with `zero`=0 → PCWrite is 1 then 0 in state 15; PCSource 01 in both.
- SUB with `overflow`=1 → R_EXEC goes to EXC with IorD 010 and EPCWrite 1; ALUOp 010 in EXC; PCSource 11 in EXC_JUMP; RegWrite never asserted.
- op 0x3F → DECODE goes to EXC with IorD 011. AND with `overflow`=1 → R_WB, no exception.
